// File: rtl/sprite_compositor.sv
// sprite_compositor: per-pixel compositor for the VGA game display.
// For each (draw_x, draw_y) it fetches the maze/food tile row, one bitmap row per sprite
// slot and one score-digit glyph row from external 1-cycle synchronous ROMs, resolves
// sprite priority with transparency, overlays the BCD score and emits 4:4:4 RGB.
// Fixed latency of 3 clocks from the sampling edge; throughput 1 pixel per clock.
//
// Ports:
//   clk, rst_n                       pixel clock, asynchronous active-low reset
//   i_pix_valid, i_draw_x, i_draw_y  active-video strobe and pixel coordinate
//   i_frame_start                    latches sprite state and score into shadow registers
//   i_spr_x/y/dir/en/col, i_score    live sprite state and BCD score (MS digit on top)
//   o_map_addr, i_map_row/food_row   maze/food ROM (one row per 16-px tile row)
//   o_spr_rom_addr, i_spr_rom_data   per-slot sprite ROM {dir, row}
//   o_num_rom_addr, i_num_rom_data   digit glyph ROM {digit, row}
//   o_rgb_valid, o_r, o_g, o_b       output pixel
module sprite_compositor #(
  parameter int unsigned NUM_SPR      = 5,
  parameter int unsigned SPR_BPP      = 4,
  parameter int unsigned SCORE_DIGITS = 4,
  parameter int unsigned SCORE_X      = 1100,
  parameter int unsigned SCORE_Y      = 16,
  parameter int unsigned MAP_W        = 80,
  parameter int unsigned MAP_H        = 50
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_pix_valid,
  input  logic                          i_frame_start,
  input  logic [10:0]                   i_draw_x,
  input  logic [9:0]                    i_draw_y,
  input  logic [NUM_SPR*11-1:0]         i_spr_x,
  input  logic [NUM_SPR*10-1:0]         i_spr_y,
  input  logic [NUM_SPR*4-1:0]          i_spr_dir,
  input  logic [NUM_SPR-1:0]            i_spr_en,
  input  logic [NUM_SPR*12-1:0]         i_spr_col,
  input  logic [4*SCORE_DIGITS-1:0]     i_score,
  output logic [5:0]                    o_map_addr,
  input  logic [MAP_W-1:0]              i_map_row,
  input  logic [MAP_W-1:0]              i_food_row,
  output logic [NUM_SPR*8-1:0]          o_spr_rom_addr,
  input  logic [NUM_SPR*16*SPR_BPP-1:0] i_spr_rom_data,
  output logic [7:0]                    o_num_rom_addr,
  input  logic [15:0]                   i_num_rom_data,
  output logic                          o_rgb_valid,
  output logic [3:0]                    o_r,
  output logic [3:0]                    o_g,
  output logic [3:0]                    o_b
);

  localparam int unsigned DIG_W = (SCORE_DIGITS > 1) ? $clog2(SCORE_DIGITS) : 1;
  localparam logic [11:0] SX_LO   = 12'(SCORE_X);
  localparam logic [11:0] SX_HI   = 12'(SCORE_X + 16 * SCORE_DIGITS);
  localparam logic [11:0] SY_LO   = 12'(SCORE_Y);
  localparam logic [11:0] SY_HI   = 12'(SCORE_Y + 16);
  localparam logic [11:0] MAP_W_L = 12'(MAP_W);
  localparam logic [11:0] MAP_H_L = 12'(MAP_H);
  localparam logic [SPR_BPP-1:0] EYE_IDX = SPR_BPP'(7);

  // Frame-latched shadows: rendering never sees the live inputs.
  logic [NUM_SPR*11-1:0]      r_spr_x;
  logic [NUM_SPR*10-1:0]      r_spr_y;
  logic [NUM_SPR*4-1:0]       r_spr_dir;
  logic [NUM_SPR-1:0]         r_spr_en;
  logic [NUM_SPR*12-1:0]      r_spr_col;
  logic [4*SCORE_DIGITS-1:0]  r_score;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spr_x   <= '0;
      r_spr_y   <= '0;
      r_spr_dir <= '0;
      r_spr_en  <= '0;
      r_spr_col <= '0;
      r_score   <= '0;
    end else if (i_frame_start) begin
      r_spr_x   <= i_spr_x;
      r_spr_y   <= i_spr_y;
      r_spr_dir <= i_spr_dir;
      r_spr_en  <= i_spr_en;
      r_spr_col <= i_spr_col;
      r_score   <= i_score;
    end
  end

  // ---- Stage A: hit tests and ROM addresses (sampling edge) ----
  logic [11:0]                  w_x, w_y;
  logic [NUM_SPR-1:0]           w_hit;
  logic [NUM_SPR-1:0][3:0]      w_sox;
  logic [NUM_SPR-1:0][7:0]      w_spr_addr;
  logic                         w_score_hit, w_onmap;
  logic [DIG_W+3:0]             w_sdx;
  logic [3:0]                   w_gy;
  logic [3:0]                   w_dig_rev [SCORE_DIGITS];

  assign w_x = {1'b0, i_draw_x};
  assign w_y = {2'b0, i_draw_y};

  for (genvar k = 0; k < NUM_SPR; k++) begin : g_slot_hit
    logic [11:0] w_kx, w_ky;
    assign w_kx = {1'b0, r_spr_x[11*k +: 11]};
    assign w_ky = {2'b0, r_spr_y[10*k +: 10]};
    assign w_hit[k] = r_spr_en[k] && (w_x >= w_kx) && (w_x < w_kx + 12'd16) &&
                      (w_y >= w_ky) && (w_y < w_ky + 12'd16);
    // Only the low nibble of the offset matters once the hit test has passed.
    assign w_sox[k]      = i_draw_x[3:0] - r_spr_x[11*k +: 4];
    assign w_spr_addr[k] = {r_spr_dir[4*k +: 4], i_draw_y[3:0] - r_spr_y[10*k +: 4]};
  end

  // Digit 0 is the most significant, i.e. the top nibble of the score.
  for (genvar d = 0; d < SCORE_DIGITS; d++) begin : g_digit
    assign w_dig_rev[d] = r_score[4*(SCORE_DIGITS-1-d) +: 4];
  end

  assign w_score_hit = (w_x >= SX_LO) && (w_x < SX_HI) && (w_y >= SY_LO) && (w_y < SY_HI);
  assign w_sdx       = w_x[DIG_W+3:0] - SX_LO[DIG_W+3:0];
  assign w_gy        = i_draw_y[3:0] - SY_LO[3:0];
  assign w_onmap     = ({5'd0, i_draw_x[10:4]} < MAP_W_L) && ({6'd0, i_draw_y[9:4]} < MAP_H_L);

  logic                          r_a_valid, r_a_onmap, r_a_shit;
  logic [6:0]                    r_a_tcol;
  logic [3:0]                    r_a_offx, r_a_offy, r_a_gcol;
  logic [NUM_SPR-1:0]            r_a_hit;
  logic [NUM_SPR-1:0][3:0]       r_a_sox;
  logic [NUM_SPR-1:0][11:0]      r_a_col;

  // ---- Stage B: wait for ROM data ----
  logic                          r_b_valid, r_b_onmap, r_b_shit;
  logic [6:0]                    r_b_tcol;
  logic [3:0]                    r_b_offx, r_b_offy, r_b_gcol;
  logic [NUM_SPR-1:0]            r_b_hit;
  logic [NUM_SPR-1:0][3:0]       r_b_sox;
  logic [NUM_SPR-1:0][11:0]      r_b_col;

  // ---- Stage C: pixel selection from ROM rows ----
  logic [NUM_SPR-1:0][15:0][SPR_BPP-1:0] w_spr_rows;
  logic [NUM_SPR-1:0][SPR_BPP-1:0]       w_idx;
  logic                                  w_map_bit, w_food_bit, w_food_px;

  assign w_spr_rows = i_spr_rom_data;
  for (genvar k = 0; k < NUM_SPR; k++) begin : g_slot_pix
    assign w_idx[k] = r_b_hit[k] ? w_spr_rows[k][r_b_sox[k]] : '0;
  end
  assign w_map_bit  = i_map_row[r_b_tcol];
  assign w_food_bit = i_food_row[r_b_tcol];
  // Food pellet is the 4x4 block in the middle of the tile.
  assign w_food_px  = (r_b_offx >= 4'd6) && (r_b_offx <= 4'd9) &&
                      (r_b_offy >= 4'd6) && (r_b_offy <= 4'd9);

  logic                            r_c_valid, r_c_shit, r_c_glyph, r_c_food, r_c_wall;
  logic [NUM_SPR-1:0][SPR_BPP-1:0] r_c_idx;
  logic [NUM_SPR-1:0][11:0]        r_c_col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_map_addr     <= '0;
      o_spr_rom_addr <= '0;
      o_num_rom_addr <= '0;
      r_a_valid <= 1'b0; r_a_onmap <= 1'b0; r_a_shit <= 1'b0; r_a_tcol <= '0;
      r_a_offx  <= '0;   r_a_offy  <= '0;   r_a_gcol <= '0;   r_a_hit  <= '0;
      r_a_sox   <= '0;   r_a_col   <= '0;
      r_b_valid <= 1'b0; r_b_onmap <= 1'b0; r_b_shit <= 1'b0; r_b_tcol <= '0;
      r_b_offx  <= '0;   r_b_offy  <= '0;   r_b_gcol <= '0;   r_b_hit  <= '0;
      r_b_sox   <= '0;   r_b_col   <= '0;
      r_c_valid <= 1'b0; r_c_shit  <= 1'b0; r_c_glyph <= 1'b0; r_c_food <= 1'b0;
      r_c_wall  <= 1'b0; r_c_idx   <= '0;   r_c_col   <= '0;
    end else begin
      o_map_addr     <= i_draw_y[9:4];
      o_spr_rom_addr <= w_spr_addr;
      o_num_rom_addr <= {w_dig_rev[w_sdx[DIG_W+3:4]], w_gy};
      r_a_valid <= i_pix_valid;
      r_a_onmap <= w_onmap;
      r_a_shit  <= w_score_hit;
      r_a_tcol  <= i_draw_x[10:4];
      r_a_offx  <= i_draw_x[3:0];
      r_a_offy  <= i_draw_y[3:0];
      r_a_gcol  <= w_sdx[3:0];
      r_a_hit   <= w_hit;
      r_a_sox   <= w_sox;
      // Colours travel with the pixel so a frame_start mid-pipeline cannot tear it.
      r_a_col   <= r_spr_col;

      r_b_valid <= r_a_valid; r_b_onmap <= r_a_onmap; r_b_shit <= r_a_shit;
      r_b_tcol  <= r_a_tcol;  r_b_offx  <= r_a_offx;  r_b_offy <= r_a_offy;
      r_b_gcol  <= r_a_gcol;  r_b_hit   <= r_a_hit;   r_b_sox  <= r_a_sox;
      r_b_col   <= r_a_col;

      r_c_valid <= r_b_valid;
      r_c_shit  <= r_b_shit;
      r_c_glyph <= i_num_rom_data[r_b_gcol];
      r_c_food  <= r_b_onmap & w_map_bit & w_food_bit & w_food_px;
      r_c_wall  <= r_b_onmap & ~w_map_bit;
      r_c_idx   <= w_idx;
      r_c_col   <= r_b_col;
    end
  end

  // ---- Stage D: priority mux ----
  logic [11:0] w_rgb;

  always_comb begin
    w_rgb = 12'h000;
    if (r_c_shit) begin
      w_rgb = r_c_glyph ? 12'hFFF : 12'h000;
    end else if (r_c_food) begin
      w_rgb = 12'hFFF;
    end else if (r_c_wall) begin
      w_rgb = 12'h00A;
    end
    // Walk from the lowest priority slot up so the lowest opaque index wins.
    for (int k = int'(NUM_SPR) - 1; k >= 0; k--) begin
      if (r_c_idx[k] != '0) begin
        w_rgb = (r_c_idx[k] == EYE_IDX) ? 12'hFFF : r_c_col[k];
      end
    end
    if (!r_c_valid) begin
      w_rgb = 12'h000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rgb_valid <= 1'b0;
      o_r <= '0;
      o_g <= '0;
      o_b <= '0;
    end else begin
      o_rgb_valid <= r_c_valid;
      o_r <= w_rgb[11:8];
      o_g <= w_rgb[7:4];
      o_b <= w_rgb[3:0];
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench for sprite_compositor: synchronous ROM models, a per-pixel
// reference model of the compositing rules, and directed plus randomized scenarios.
module tb_sprite_compositor;

  localparam int NS = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              pix_valid, frame_start;
  logic [10:0]       draw_x;
  logic [9:0]        draw_y;
  logic [NS*11-1:0]  spr_x;
  logic [NS*10-1:0]  spr_y;
  logic [NS*4-1:0]   spr_dir;
  logic [NS-1:0]     spr_en;
  logic [NS*12-1:0]  spr_col;
  logic [15:0]       score;
  logic [5:0]        map_addr;
  logic [79:0]       map_row, food_row;
  logic [NS*8-1:0]   spr_rom_addr;
  logic [NS*64-1:0]  spr_rom_data;
  logic [7:0]        num_rom_addr;
  logic [15:0]       num_rom_data;
  logic              rgb_valid;
  logic [3:0]        r, g, b;

  sprite_compositor dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_pix_valid    (pix_valid),
    .i_frame_start  (frame_start),
    .i_draw_x       (draw_x),
    .i_draw_y       (draw_y),
    .i_spr_x        (spr_x),
    .i_spr_y        (spr_y),
    .i_spr_dir      (spr_dir),
    .i_spr_en       (spr_en),
    .i_spr_col      (spr_col),
    .i_score        (score),
    .o_map_addr     (map_addr),
    .i_map_row      (map_row),
    .i_food_row     (food_row),
    .o_spr_rom_addr (spr_rom_addr),
    .i_spr_rom_data (spr_rom_data),
    .o_num_rom_addr (num_rom_addr),
    .i_num_rom_data (num_rom_data),
    .o_rgb_valid    (rgb_valid),
    .o_r            (r),
    .o_g            (g),
    .o_b            (b)
  );

  // ROM contents
  logic [79:0] map_mem  [64];
  logic [79:0] food_mem [64];
  logic [3:0]  spr_mem  [256][16];
  logic [15:0] num_mem  [256];

  always @(posedge clk) begin
    map_row      <= map_mem[map_addr];
    food_row     <= food_mem[map_addr];
    num_rom_data <= num_mem[num_rom_addr];
    for (int k = 0; k < NS; k++)
      for (int c = 0; c < 16; c++)
        spr_rom_data[k*64 + c*4 +: 4] <= spr_mem[spr_rom_addr[k*8 +: 8]][c];
  end

  // Reference model shadow state
  int          m_x [NS], m_y [NS], m_dir [NS];
  bit          m_en [NS];
  logic [11:0] m_col [NS];
  int          m_score;

  int n_checks = 0;
  int n_errors = 0;
  logic [12:0] exp_q[$], obs_q[$];

  function automatic logic [12:0] model(int x, int y, bit v);
    int tc, tr, ox, oy, d, idx;
    if (!v) return 13'h0;
    for (int k = 0; k < NS; k++) begin
      if (m_en[k] && x >= m_x[k] && x < m_x[k] + 16 && y >= m_y[k] && y < m_y[k] + 16) begin
        idx = int'(spr_mem[m_dir[k]*16 + (y - m_y[k])][x - m_x[k]]);
        if (idx == 7) return {1'b1, 12'hFFF};
        if (idx != 0) return {1'b1, m_col[k]};
      end
    end
    if (x >= 1100 && x < 1164 && y >= 16 && y < 32) begin
      d   = (x - 1100) / 16;
      idx = (m_score >> (4 * (3 - d))) & 15;
      return num_mem[idx*16 + (y - 16)][(x - 1100) % 16] ? {1'b1, 12'hFFF} : {1'b1, 12'h000};
    end
    tc = x / 16;
    tr = y / 16;
    if (tc >= 80 || tr >= 50) return {1'b1, 12'h000};
    ox = x % 16;
    oy = y % 16;
    if (map_mem[tr][tc] && food_mem[tr][tc] && ox >= 6 && ox <= 9 && oy >= 6 && oy <= 9)
      return {1'b1, 12'hFFF};
    if (!map_mem[tr][tc]) return {1'b1, 12'h00A};
    return {1'b1, 12'h000};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NS; k++) begin
      m_x[k] = 0; m_y[k] = 0; m_dir[k] = 0; m_en[k] = 0; m_col[k] = 12'h0;
    end
    m_score = 0;
  endtask

  // Drive one pixel for one clock; record the expected result and the output after the edge.
  task automatic px(input int x, input int y, input bit v, input bit fs);
    draw_x = 11'(x);
    draw_y = 10'(y);
    pix_valid = v;
    frame_start = fs;
    exp_q.push_back(model(x, y, v));
    @(posedge clk);
    if (fs) begin
      for (int k = 0; k < NS; k++) begin
        m_x[k]   = int'(spr_x[11*k +: 11]);
        m_y[k]   = int'(spr_y[10*k +: 10]);
        m_dir[k] = int'(spr_dir[4*k +: 4]);
        m_en[k]  = spr_en[k];
        m_col[k] = spr_col[12*k +: 12];
      end
      m_score = int'(score);
    end
    #1;
    obs_q.push_back({rgb_valid, r, g, b});
  endtask

  task automatic flush();
    repeat (3) px(0, 0, 0, 0);
  endtask

  task automatic set_slot(input int k, input int x, input int y, input int dir, input bit en,
                          input logic [11:0] col);
    spr_x[11*k +: 11] = 11'(x);
    spr_y[10*k +: 10] = 10'(y);
    spr_dir[4*k +: 4] = 4'(dir);
    spr_en[k]         = en;
    spr_col[12*k +: 12] = col;
  endtask

  task automatic test_reset();
    exp_q.delete(); obs_q.delete();
    repeat (4) px(40, 40, 1, 0);
    n_checks++;
    if (rgb_valid !== 1'b1) begin
      n_errors++; $display("FAIL reset_pre_valid got %b want 1", rgb_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rgb_valid, r, g, b} !== 13'h0) begin
      n_errors++; $display("FAIL reset_async_out got %h want 0", {rgb_valid, r, g, b});
    end
    n_checks++;
    if (map_addr !== 6'd0) begin
      n_errors++; $display("FAIL reset_map_addr got %h want 0", map_addr);
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    exp_q.delete(); obs_q.delete();
    px(40, 40, 1, 0);
    flush();
    n_checks++;
    if (obs_q[2][12] !== 1'b0) begin
      n_errors++; $display("FAIL reset_latency_early got %b want 0", obs_q[2][12]);
    end
    n_checks++;
    if (obs_q[3] !== exp_q[0]) begin
      n_errors++; $display("FAIL reset_first_pixel got %h want %h", obs_q[3], exp_q[0]);
    end
  endtask

  task automatic test_sprite_basic();
    for (int row = 32; row < 48; row++)
      for (int c = 0; c < 16; c++) spr_mem[row][c] = 4'd3;
    spr_en = '0;
    set_slot(0, 100, 100, 2, 1'b1, 12'h5C3);
    exp_q.delete(); obs_q.delete();
    px(0, 0, 0, 1);
    px(100, 100, 1, 0);
    n_checks++;
    if (spr_rom_addr[7:0] !== 8'h20) begin
      n_errors++; $display("FAIL spr_addr_top got %h want 20", spr_rom_addr[7:0]);
    end
    px(115, 100, 1, 0);
    px(99, 100, 1, 0);
    px(116, 100, 1, 0);
    px(107, 115, 1, 0);
    n_checks++;
    if (spr_rom_addr[7:0] !== 8'h2F) begin
      n_errors++; $display("FAIL spr_addr_bottom got %h want 2f", spr_rom_addr[7:0]);
    end
    px(107, 116, 1, 0);
    flush();
    n_checks++;
    if (obs_q[4] !== {1'b1, 12'h5C3}) begin
      n_errors++; $display("FAIL spr_left_edge got %h want 15c3", obs_q[4]);
    end
    n_checks++;
    if (obs_q[5] !== {1'b1, 12'h5C3}) begin
      n_errors++; $display("FAIL spr_right_edge got %h want 15c3", obs_q[5]);
    end
    for (int i = 0; i + 3 < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i+3] !== exp_q[i]) begin
        n_errors++; $display("FAIL spr_basic_stream pix %0d got %h want %h", i, obs_q[i+3], exp_q[i]);
      end
    end
  endtask

  task automatic test_overlap();
    spr_mem[64][0] = 4'd0; spr_mem[80][0] = 4'd3;
    spr_mem[64][1] = 4'd7; spr_mem[80][1] = 4'd3;
    spr_en = '0;
    set_slot(0, 200, 200, 4, 1'b1, 12'h9A4);
    set_slot(1, 200, 200, 5, 1'b1, 12'h1E2);
    exp_q.delete(); obs_q.delete();
    px(0, 0, 0, 1);
    px(200, 200, 1, 0);
    px(201, 200, 1, 0);
    flush();
    n_checks++;
    if (obs_q[4] !== {1'b1, 12'h1E2}) begin
      n_errors++; $display("FAIL overlap_transparent got %h want 11e2", obs_q[4]);
    end
    n_checks++;
    if (obs_q[5] !== {1'b1, 12'hFFF}) begin
      n_errors++; $display("FAIL overlap_eyes got %h want 1fff", obs_q[5]);
    end
    for (int i = 0; i + 3 < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i+3] !== exp_q[i]) begin
        n_errors++; $display("FAIL overlap_stream pix %0d got %h want %h", i, obs_q[i+3], exp_q[i]);
      end
    end
  endtask

  task automatic test_shadow();
    spr_en = '0;
    set_slot(0, 300, 300, 2, 1'b1, 12'h3C7);
    exp_q.delete(); obs_q.delete();
    px(0, 0, 0, 1);
    px(305, 305, 1, 0);
    px(320, 305, 1, 0);
    spr_x[10:0] = 11'd310;
    px(305, 305, 1, 0);
    px(320, 305, 1, 0);
    px(312, 305, 1, 1);
    px(305, 305, 1, 0);
    px(320, 305, 1, 0);
    flush();
    n_checks++;
    if (obs_q[6] !== {1'b1, 12'h3C7}) begin
      n_errors++; $display("FAIL shadow_no_latch got %h want 13c7", obs_q[6]);
    end
    n_checks++;
    if (obs_q[8] !== {1'b1, 12'h3C7}) begin
      n_errors++; $display("FAIL shadow_latch_edge got %h want 13c7", obs_q[8]);
    end
    n_checks++;
    if (obs_q[10] !== {1'b1, 12'h3C7}) begin
      n_errors++; $display("FAIL shadow_moved got %h want 13c7", obs_q[10]);
    end
    for (int i = 0; i + 3 < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i+3] !== exp_q[i]) begin
        n_errors++; $display("FAIL shadow_stream pix %0d got %h want %h", i, obs_q[i+3], exp_q[i]);
      end
    end
  endtask

  task automatic test_score();
    spr_en = '0;
    score = 16'h1234;
    num_mem[8'h34] = 16'h0020;
    exp_q.delete(); obs_q.delete();
    px(0, 0, 0, 1);
    px(1137, 20, 1, 0);
    n_checks++;
    if (num_rom_addr !== 8'h34) begin
      n_errors++; $display("FAIL score_addr got %h want 34", num_rom_addr);
    end
    px(1136, 20, 1, 0);
    for (int i = 0; i < 24; i++)
      px($urandom_range(1096, 1167), $urandom_range(14, 33), 1, 0);
    flush();
    n_checks++;
    if (obs_q[4] !== {1'b1, 12'hFFF}) begin
      n_errors++; $display("FAIL score_glyph_on got %h want 1fff", obs_q[4]);
    end
    n_checks++;
    if (obs_q[5] !== {1'b1, 12'h000}) begin
      n_errors++; $display("FAIL score_glyph_off got %h want 1000", obs_q[5]);
    end
    for (int i = 0; i + 3 < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i+3] !== exp_q[i]) begin
        n_errors++; $display("FAIL score_stream pix %0d got %h want %h", i, obs_q[i+3], exp_q[i]);
      end
    end
  endtask

  task automatic test_map();
    spr_en = '0;
    map_mem[4][3]  = 1'b1;
    food_mem[4][3] = 1'b1;
    exp_q.delete(); obs_q.delete();
    px(0, 0, 0, 1);
    px(55, 71, 1, 0);
    px(53, 71, 1, 0);
    flush();
    n_checks++;
    if (obs_q[4] !== {1'b1, 12'hFFF}) begin
      n_errors++; $display("FAIL map_food got %h want 1fff", obs_q[4]);
    end
    n_checks++;
    if (obs_q[5] !== {1'b1, 12'h000}) begin
      n_errors++; $display("FAIL map_food_edge got %h want 1000", obs_q[5]);
    end
    map_mem[4][3] = 1'b0;
    exp_q.delete(); obs_q.delete();
    px(55, 71, 1, 0);
    px(55, 800, 1, 0);
    px(1290, 100, 1, 0);
    px(55, 71, 0, 0);
    flush();
    n_checks++;
    if (obs_q[3] !== {1'b1, 12'h00A}) begin
      n_errors++; $display("FAIL map_wall got %h want 100a", obs_q[3]);
    end
    n_checks++;
    if (obs_q[4] !== {1'b1, 12'h000}) begin
      n_errors++; $display("FAIL map_off_rows got %h want 1000", obs_q[4]);
    end
    n_checks++;
    if (obs_q[5] !== {1'b1, 12'h000}) begin
      n_errors++; $display("FAIL map_off_cols got %h want 1000", obs_q[5]);
    end
    n_checks++;
    if (obs_q[6] !== 13'h0) begin
      n_errors++; $display("FAIL map_blanking got %h want 0", obs_q[6]);
    end
  endtask

  task automatic test_random();
    int k, x, y;
    exp_q.delete(); obs_q.delete();
    for (int f = 0; f < 8; f++) begin
      for (int s = 0; s < NS; s++)
        set_slot(s, $urandom_range(0, 400), $urandom_range(0, 300), $urandom_range(0, 15),
                 1'($urandom_range(0, 3) != 0), 12'($urandom));
      if (f % 3 == 0) set_slot(4, 2040, 1018, 1, 1'b1, 12'h6B1);
      score = 16'($urandom);
      px(0, 0, 0, 1);
      for (int i = 0; i < 250; i++) begin
        k = $urandom_range(0, NS - 1);
        case ($urandom_range(0, 3))
          0, 1: begin
            x = int'(spr_x[11*k +: 11]) + $urandom_range(0, 19) - 2;
            y = int'(spr_y[10*k +: 10]) + $urandom_range(0, 19) - 2;
          end
          2: begin
            x = $urandom_range(1096, 1167);
            y = $urandom_range(14, 33);
          end
          default: begin
            x = $urandom_range(0, 2047);
            y = $urandom_range(0, 1023);
          end
        endcase
        if (x < 0) x = 0;
        if (x > 2047) x = 2047;
        if (y < 0) y = 0;
        if (y > 1023) y = 1023;
        // Occasional mid-frame relatch exercises the shadow timing.
        if ($urandom_range(0, 99) == 0) begin
          set_slot(k, $urandom_range(0, 400), $urandom_range(0, 300), $urandom_range(0, 15),
                   1'b1, 12'($urandom));
          px(x, y, 1'($urandom_range(0, 9) != 0), 1);
        end else begin
          px(x, y, 1'($urandom_range(0, 9) != 0), 0);
        end
      end
    end
    flush();
    for (int i = 0; i + 3 < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i+3] !== exp_q[i]) begin
        n_errors++; $display("FAIL random_stream pix %0d got %h want %h", i, obs_q[i+3], exp_q[i]);
      end
    end
  endtask

  initial begin
    int v;
    rst_n = 1'b0;
    pix_valid = 1'b0; frame_start = 1'b0; draw_x = '0; draw_y = '0;
    spr_x = '0; spr_y = '0; spr_dir = '0; spr_en = '0; spr_col = '0; score = '0;
    for (int i = 0; i < 64; i++) begin
      map_mem[i]  = {$urandom, $urandom, $urandom};
      food_mem[i] = {$urandom, $urandom, $urandom};
    end
    for (int i = 0; i < 256; i++) begin
      num_mem[i] = 16'($urandom);
      for (int c = 0; c < 16; c++) begin
        v = $urandom_range(0, 15);
        spr_mem[i][c] = (v > 10) ? 4'd0 : 4'(v);
      end
    end
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    test_reset();
    test_sprite_basic();
    test_overlap();
    test_shadow();
    test_score();
    test_map();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
